// File: rtl/fire_ram_pkg.sv
// Shared definitions for the multi-read distributed RAM family with built-in clear sequencer.
package fire_ram_pkg;

  typedef enum logic {
    CLR_CLEAR = 1'b0,
    CLR_RUN   = 1'b1
  } clr_state_e;

  // Read latency in cycles for a given output-register setting.
  function automatic int unsigned rd_lat(input int unsigned out_reg);
    return (out_reg != 0) ? 2 : 1;
  endfunction

  // Low bit of column col in a word of col_width-bit columns.
  function automatic int unsigned col_lsb(input int unsigned col, input int unsigned col_width);
    return col * col_width;
  endfunction

endpackage

// File: rtl/dist_ram_clr_seq.sv
// Clear sequencer: walks every RAM entry writing INIT_VALUE after reset or on init_req,
// and muxes either the clear write or the user write onto the RAM write port.
module dist_ram_clr_seq
  import fire_ram_pkg::*;
#(
  parameter int unsigned NUM_COL    = 16,
  parameter int unsigned COL_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter logic [NUM_COL*COL_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          init_req,
  input  logic [NUM_COL-1:0]            wr_en,
  input  logic [ADDR_WIDTH-1:0]         wr_addr,
  input  logic [NUM_COL*COL_WIDTH-1:0]  wr_din,
  output logic                          init_busy,
  output logic                          out_zero_c,
  output logic [NUM_COL-1:0]            ram_wen_c,
  output logic [ADDR_WIDTH-1:0]         ram_addr_c,
  output logic [NUM_COL*COL_WIDTH-1:0]  ram_din_c
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  clr_state_e            state, state_nxt;
  logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= CLR_CLEAR;
      cnt       <= '0;
      init_busy <= 1'b1;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      init_busy <= (state_nxt == CLR_CLEAR);
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      CLR_CLEAR: begin
        if (init_req) begin
          cnt_nxt = '0;
        end else if (cnt == LAST_ADDR) begin
          state_nxt = CLR_RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + ADDR_WIDTH'(1);
        end
      end
      CLR_RUN: begin
        if (init_req) begin
          state_nxt = CLR_CLEAR;
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = CLR_CLEAR;
    endcase
  end

  // Output stages are zeroed on every clear cycle and on the cycle entering clear,
  // so nothing read before or during the sweep ever reaches the user.
  always_comb begin
    ram_wen_c  = wr_en;
    ram_addr_c = wr_addr;
    ram_din_c  = wr_din;
    out_zero_c = (state_nxt == CLR_CLEAR);
    if (state == CLR_CLEAR) begin
      out_zero_c = 1'b1;
      ram_wen_c  = '1;
      ram_addr_c = cnt;
      ram_din_c  = INIT_VALUE;
    end
  end

endmodule

// File: rtl/dist_ram_mr_init.sv
// Byte-column distributed RAM: one write port with write-first readback, NUM_RD read ports,
// selectable read-during-write bypass, optional extra output register, self-clearing.
module dist_ram_mr_init
  import fire_ram_pkg::*;
#(
  parameter int unsigned NUM_COL    = 16,
  parameter int unsigned COL_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_RD     = 2,
  parameter int unsigned BYPASS     = 1,
  parameter int unsigned OUT_REG    = 0,
  parameter logic [NUM_COL*COL_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                init_req,
  output logic                                init_busy,
  input  logic [NUM_COL-1:0]                  wr_en,
  input  logic [ADDR_WIDTH-1:0]               wr_addr,
  input  logic [NUM_COL*COL_WIDTH-1:0]        wr_din,
  output logic [NUM_COL*COL_WIDTH-1:0]        wr_dout,
  input  logic [NUM_RD*ADDR_WIDTH-1:0]        rd_addr,
  output logic [NUM_RD*NUM_COL*COL_WIDTH-1:0] rd_dout
);

  localparam int unsigned W      = NUM_COL * COL_WIDTH;
  localparam int unsigned DEPTH  = 2 ** ADDR_WIDTH;
  localparam int unsigned RD_LAT = rd_lat(OUT_REG);

  logic                  out_zero_c;
  logic [NUM_COL-1:0]    ram_wen_c;
  logic [ADDR_WIDTH-1:0] ram_addr_c;
  logic [W-1:0]          ram_din_c;

  dist_ram_clr_seq #(
    .NUM_COL    (NUM_COL),
    .COL_WIDTH  (COL_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .INIT_VALUE (INIT_VALUE)
  ) u_clr_seq (
    .clock      (clock),
    .reset      (reset),
    .init_req   (init_req),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_din     (wr_din),
    .init_busy  (init_busy),
    .out_zero_c (out_zero_c),
    .ram_wen_c  (ram_wen_c),
    .ram_addr_c (ram_addr_c),
    .ram_din_c  (ram_din_c)
  );

  (* ram_style = "distributed" *) logic [W-1:0] mem [DEPTH];

  // Storage has no reset; the clear sequencer owns its initial contents.
  always_ff @(posedge clock) begin
    for (int c = 0; c < NUM_COL; c++) begin
      if (ram_wen_c[c]) begin
        mem[ram_addr_c][col_lsb(c, COL_WIDTH) +: COL_WIDTH] <= ram_din_c[col_lsb(c, COL_WIDTH) +: COL_WIDTH];
      end
    end
  end

  logic [W-1:0]        wr_next_c;
  logic [NUM_RD*W-1:0] rd_next_c;

  always_comb begin
    wr_next_c = mem[ram_addr_c];
    for (int c = 0; c < NUM_COL; c++) begin
      if (ram_wen_c[c]) begin
        wr_next_c[col_lsb(c, COL_WIDTH) +: COL_WIDTH] = ram_din_c[col_lsb(c, COL_WIDTH) +: COL_WIDTH];
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] addr_c;
    logic [W-1:0]          word_c;

    assign addr_c = rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];

    always_comb begin
      word_c = mem[addr_c];
      if ((BYPASS != 0) && (addr_c == ram_addr_c)) begin
        for (int c = 0; c < NUM_COL; c++) begin
          if (ram_wen_c[c]) begin
            word_c[col_lsb(c, COL_WIDTH) +: COL_WIDTH] = ram_din_c[col_lsb(c, COL_WIDTH) +: COL_WIDTH];
          end
        end
      end
    end

    assign rd_next_c[k*W +: W] = word_c;
  end

  logic [W-1:0]        wr_s1;
  logic [NUM_RD*W-1:0] rd_s1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_s1 <= '0;
      rd_s1 <= '0;
    end else if (out_zero_c) begin
      wr_s1 <= '0;
      rd_s1 <= '0;
    end else begin
      wr_s1 <= wr_next_c;
      rd_s1 <= rd_next_c;
    end
  end

  if (RD_LAT == 2) begin : g_out_reg
    logic [W-1:0]        wr_s2;
    logic [NUM_RD*W-1:0] rd_s2;

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        wr_s2 <= '0;
        rd_s2 <= '0;
      end else if (out_zero_c) begin
        wr_s2 <= '0;
        rd_s2 <= '0;
      end else begin
        wr_s2 <= wr_s1;
        rd_s2 <= rd_s1;
      end
    end

    assign wr_dout = wr_s2;
    assign rd_dout = rd_s2;
  end else begin : g_no_out_reg
    assign wr_dout = wr_s1;
    assign rd_dout = rd_s1;
  end

endmodule

// File: tb/tb_dist_ram_mr_init.sv
// Bench for dist_ram_mr_init: two configurations share one stimulus stream,
// directed clear/write/collision scenarios followed by a randomised scoreboard run.
module tb_dist_ram_mr_init;

  localparam int unsigned NC = 16;
  localparam int unsigned CW = 32;
  localparam int unsigned W  = NC * CW;
  localparam int unsigned AW = 5;
  localparam logic [W-1:0] INIT_V = {16{32'h1357_9BDF}};

  logic            clock;
  logic            reset;
  logic            init_req;
  logic [NC-1:0]   wr_en;
  logic [AW-1:0]   wr_addr;
  logic [W-1:0]    wr_din;
  logic [4*AW-1:0] rd_addr;

  logic            a_busy, b_busy;
  logic [W-1:0]    a_wr_dout, b_wr_dout;
  logic [2*W-1:0]  a_rd_dout;
  logic [4*W-1:0]  b_rd_dout;

  int n_checks = 0;
  int n_errors = 0;

  // A: two ports, bypass, latency 1.  B: four ports, no bypass, latency 2.
  dist_ram_mr_init #(
    .NUM_COL(NC), .COL_WIDTH(CW), .ADDR_WIDTH(AW), .NUM_RD(2),
    .BYPASS(1), .OUT_REG(0), .INIT_VALUE(INIT_V)
  ) u_dut_a (
    .clock(clock), .reset(reset), .init_req(init_req), .init_busy(a_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_din(wr_din), .wr_dout(a_wr_dout),
    .rd_addr(rd_addr[2*AW-1:0]), .rd_dout(a_rd_dout)
  );

  dist_ram_mr_init #(
    .NUM_COL(NC), .COL_WIDTH(CW), .ADDR_WIDTH(AW), .NUM_RD(4),
    .BYPASS(0), .OUT_REG(1), .INIT_VALUE(INIT_V)
  ) u_dut_b (
    .clock(clock), .reset(reset), .init_req(init_req), .init_busy(b_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_din(wr_din), .wr_dout(b_wr_dout),
    .rd_addr(rd_addr), .rd_dout(b_rd_dout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Count edges until init_busy drops; the bound turns a stuck busy into a failed length check.
  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      n++;
      if (!a_busy) break;
    end
  endtask

  function automatic logic [W-1:0] rep(input logic [31:0] x);
    return {16{x}};
  endfunction

  function automatic logic [W-1:0] merge(input logic [W-1:0] base, input logic [W-1:0] din,
                                         input logic [NC-1:0] en);
    logic [W-1:0] r;
    r = base;
    for (int c = 0; c < NC; c++) if (en[c]) r[c*CW +: CW] = din[c*CW +: CW];
    return r;
  endfunction

  function automatic logic [4*AW-1:0] all_rd(input logic [AW-1:0] a);
    return {4{a}};
  endfunction

  logic [W-1:0] m_mem [32];
  logic [W-1:0] a_s1 [2];
  logic [W-1:0] b_s1 [4];
  logic [W-1:0] b_s2 [4];
  logic [W-1:0] na [2];
  logic [W-1:0] nb [4];
  logic [W-1:0] wa_s1, wb_s1, wb_s2, nw;

  initial begin
    int n;
    logic [W-1:0] col0_new;
    logic [AW-1:0] ra;

    reset = 1'b1; init_req = 1'b0; wr_en = '0; wr_addr = '0; wr_din = '0; rd_addr = '0;
    col0_new = {{15{32'h1111_1111}}, 32'hFFFF_FFFF};

    // Reset state and clear sweep length
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy_a", W'(a_busy), W'(1));
    check("rst_busy_b", W'(b_busy), W'(1));
    check("rst_wr_dout_a", a_wr_dout, '0);
    check("rst_rd_dout_b3", b_rd_dout[3*W +: W], '0);
    reset = 1'b0;
    count_busy(n);
    check("busy_len_reset", W'(n), W'(32));
    check("busy_b_done", W'(b_busy), W'(0));

    for (int a = 0; a < 32; a++) begin
      rd_addr = all_rd(AW'(a));
      tick(); tick();
      check("init_rd_a1", a_rd_dout[W +: W], INIT_V);
      check("init_rd_b3", b_rd_dout[3*W +: W], INIT_V);
    end

    // Full-word write and read back
    wr_addr = 5'd5; wr_din = rep(32'hA5A5_A5A5); wr_en = '1;
    tick();
    wr_en = '0;
    check("wr5_wr_dout_a", a_wr_dout, rep(32'hA5A5_A5A5));
    rd_addr = all_rd(5'd5);
    tick();
    check("rd5_a0_lat1", a_rd_dout[0 +: W], rep(32'hA5A5_A5A5));
    tick();
    check("rd5_b0_lat2", b_rd_dout[0 +: W], rep(32'hA5A5_A5A5));
    check("wr5_wr_dout_b", b_wr_dout, rep(32'hA5A5_A5A5));

    // Single-column write colliding with both reads
    wr_addr = 5'd7; wr_din = rep(32'h1111_1111); wr_en = '1;
    tick();
    wr_en = 16'h0001; wr_din = rep(32'hFFFF_FFFF); rd_addr = all_rd(5'd7);
    tick();
    wr_en = '0;
    check("coll_a0_bypass", a_rd_dout[0 +: W], col0_new);
    check("coll_a1_bypass", a_rd_dout[W +: W], col0_new);
    check("coll_wr_dout_a", a_wr_dout, col0_new);
    tick();
    check("coll_b0_old", b_rd_dout[0 +: W], rep(32'h1111_1111));
    check("coll_b1_old", b_rd_dout[W +: W], rep(32'h1111_1111));
    check("coll_wr_dout_b", b_wr_dout, col0_new);
    check("coll_a0_stored", a_rd_dout[0 +: W], col0_new);

    // Re-clear on request; writes during the sweep are dropped
    wr_addr = 5'd3; wr_din = rep(32'hDEAD_DEAD); wr_en = '1;
    tick();
    wr_en = '0; init_req = 1'b1;
    tick();
    init_req = 1'b0;
    check("init_busy_a", W'(a_busy), W'(1));
    check("init_rd_zero_a", a_rd_dout[0 +: W], '0);
    check("init_wr_zero_a", a_wr_dout, '0);
    wr_en = '1; wr_din = rep(32'hBEEF_BEEF);
    count_busy(n);
    check("busy_len_init", W'(n), W'(32));
    wr_en = '0; rd_addr = all_rd(5'd3);
    tick(); tick();
    check("rd3_cleared_a", a_rd_dout[0 +: W], INIT_V);
    check("rd3_cleared_b", b_rd_dout[0 +: W], INIT_V);
    check("wr3_cleared_b", b_wr_dout, INIT_V);

    // Reset in the middle of a sweep restarts it
    init_req = 1'b1;
    tick();
    init_req = 1'b0;
    repeat (17) tick();
    check("mid_busy_a", W'(a_busy), W'(1));
    reset = 1'b1;
    #1;
    check("mid_rst_rd_a", a_rd_dout[0 +: W], '0);
    check("mid_rst_wr_b", b_wr_dout, '0);
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    count_busy(n);
    check("busy_len_midrst", W'(n), W'(32));

    // Random traffic against the scoreboard, starting from a freshly cleared RAM
    for (int i = 0; i < 32; i++) m_mem[i] = INIT_V;
    for (int k = 0; k < 2; k++) a_s1[k] = '0;
    for (int k = 0; k < 4; k++) begin b_s1[k] = '0; b_s2[k] = '0; end
    wa_s1 = '0; wb_s1 = '0; wb_s2 = '0;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      wr_en   = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      wr_addr = AW'($urandom_range(0, 31));
      for (int c = 0; c < NC; c++) wr_din[c*CW +: CW] = $urandom;
      for (int k = 0; k < 4; k++)
        rd_addr[k*AW +: AW] = ($urandom_range(0, 2) == 0) ? wr_addr : AW'($urandom_range(0, 31));

      nw = merge(m_mem[wr_addr], wr_din, wr_en);
      for (int k = 0; k < 4; k++) begin
        ra = rd_addr[k*AW +: AW];
        nb[k] = m_mem[ra];
        if (k < 2) na[k] = (ra == wr_addr) ? merge(m_mem[ra], wr_din, wr_en) : m_mem[ra];
      end

      tick();
      m_mem[wr_addr] = nw;
      for (int k = 0; k < 4; k++) begin b_s2[k] = b_s1[k]; b_s1[k] = nb[k]; end
      for (int k = 0; k < 2; k++) a_s1[k] = na[k];
      wb_s2 = wb_s1; wb_s1 = nw; wa_s1 = nw;

      for (int k = 0; k < 2; k++) check($sformatf("rnd_a_rd%0d_c%0d", k, cyc), a_rd_dout[k*W +: W], a_s1[k]);
      for (int k = 0; k < 4; k++) check($sformatf("rnd_b_rd%0d_c%0d", k, cyc), b_rd_dout[k*W +: W], b_s2[k]);
      check($sformatf("rnd_a_wr_c%0d", cyc), a_wr_dout, wa_s1);
      check($sformatf("rnd_b_wr_c%0d", cyc), b_wr_dout, wb_s2);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
